// File: rtl/time_counter.sv
// Time-of-day counter for the alarm clock.
// Divides the board clock to a 1 Hz tick, keeps hours/minutes/seconds in
// plain binary, supports manual time setting and rings when the running
// time reaches the armed alarm time.
module time_counter #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int RING_SECONDS = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       set_en,
   input  logic       hour_inc,
   input  logic       min_inc,
   input  logic [4:0] alarm_hr,
   input  logic [5:0] alarm_min,
   input  logic       alarm_en,
   input  logic       alarm_stop,
   output logic [6:0] hours,
   output logic [6:0] minutes,
   output logic [6:0] seconds,
   output logic       tick_1hz,
   output logic       alarm_ring
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int RW = $clog2(RING_SECONDS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECONDS);
   localparam logic [RW-1:0] RING_LAST = RW'(1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RING = 1'b1;

   logic [PW-1:0] presc;
   logic [4:0]    hr;
   logic [5:0]    mn;
   logic [5:0]    sc;
   logic [4:0]    hr_next;
   logic [5:0]    mn_next;
   logic [5:0]    sc_next;
   logic          tick_now;
   logic          sec_wrap;
   logic          min_wrap;
   logic          match;
   logic [0:0]    state;
   logic [RW-1:0] ring_cnt;

   // Decide whether this cycle produces a tick, what the time becomes after
   // it, and whether that new time is the armed alarm time.  Comparing the
   // post-tick time lets the ring start on the same edge the time appears.
   always_comb begin
      tick_now = run && !set_en && (presc == PRESC_MAX);
      sec_wrap = (sc == 6'd59);
      min_wrap = (mn == 6'd59);
      sc_next  = sec_wrap ? 6'd0 : sc + 6'd1;
      mn_next  = mn;
      hr_next  = hr;
      if (sec_wrap) begin
         mn_next = min_wrap ? 6'd0 : mn + 6'd1;
         if (min_wrap) begin
            hr_next = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
         end
      end
      match = tick_now && alarm_en && (hr_next == alarm_hr) &&
              (mn_next == alarm_min) && (sc_next == 6'd0);
   end

   // Prescaler: held at zero in set mode, frozen when not running, and
   // otherwise counting 0..CLK_HZ-1 with a wrap on the tick cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (set_en) begin
         presc <= '0;
      end else if (run) begin
         if (presc == PRESC_MAX) begin
            presc <= '0;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // Registered tick pulse, high for exactly the cycle after the decision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_1hz <= 1'b0;
      end else begin
         tick_1hz <= tick_now;
      end
   end

   // Time fields: set mode edits hours/minutes independently and pins
   // seconds to zero; otherwise a tick advances the full carry chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hr <= 5'd0;
         mn <= 6'd0;
         sc <= 6'd0;
      end else if (set_en) begin
         sc <= 6'd0;
         if (hour_inc) begin
            hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
         end
         if (min_inc) begin
            mn <= (mn == 6'd59) ? 6'd0 : mn + 6'd1;
         end
      end else if (tick_now) begin
         hr <= hr_next;
         mn <= mn_next;
         sc <= sc_next;
      end
   end

   // Alarm FSM: a tick landing on the alarm time starts the ring; stop has
   // top priority, disarming also ends it, else it times out after
   // RING_SECONDS further ticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ring_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (match) begin
                  state    <= RING;
                  ring_cnt <= RING_LOAD;
               end
            end
            RING: begin
               if (alarm_stop || !alarm_en) begin
                  state    <= IDLE;
                  ring_cnt <= '0;
               end else if (tick_now) begin
                  if (ring_cnt <= RING_LAST) begin
                     state    <= IDLE;
                     ring_cnt <= '0;
                  end else begin
                     ring_cnt <= ring_cnt - RW'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               ring_cnt <= '0;
            end
         endcase
      end
   end

   assign hours      = {2'b00, hr};
   assign minutes    = {1'b0, mn};
   assign seconds    = {1'b0, sc};
   assign alarm_ring = (state == RING);

endmodule
